// File: rtl/net_pc_launcher.sv
// rtl/net_pc_launcher.sv - launches a core by sending a PC-write packet and tracking its run state
// Optional RUN watchdog enabled by defining NET_LAUNCH_TIMEOUT_EN.
module net_pc_launcher #(
    parameter int IMEM_ADDR_W = 10,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   start_i,
    input  logic [IMEM_ADDR_W-1:0] start_pc_i,
    output logic                   net_valid_o,
    input  logic                   net_ready_i,
    output logic [IMEM_ADDR_W-1:0] net_pc_o,
    input  logic [1:0]             core_state_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   timeout_o
);

    typedef enum logic [1:0] {
        L_IDLE,
        L_SEND,
        L_WAIT_RUN,
        L_RUN
    } state_t;

    state_t                 state, state_nxt;
    logic [IMEM_ADDR_W-1:0] pc_q;
    logic                   err_q;
    logic                   set_err;
    logic                   core_err, core_idle, core_run;
    logic                   in_wait;
    logic                   wd_expire;
    logic                   accept;

    // Encoding 3 is undefined on the core side and is handled as an error.
    assign core_err  = core_state_i[1];
    assign core_idle = (core_state_i == 2'd0);
    assign core_run  = (core_state_i == 2'd1);
    assign in_wait   = (state == L_WAIT_RUN) || (state == L_RUN);
    assign accept    = (state == L_IDLE) && start_i;

`ifdef NET_LAUNCH_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 to_q;

    // Expire on the cycle whose increment would make the counter all-ones.
    assign wd_expire = in_wait && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wd_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            if (state == L_SEND && state_nxt == L_WAIT_RUN) begin
                wd_cnt <= '0;
            end else if (in_wait) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (accept) begin
                to_q <= 1'b0;
            end else if (wd_expire) begin
                to_q <= 1'b1;
            end
        end
    end

    assign timeout_o = to_q;
`else
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        set_err     = 1'b0;
        done_o      = 1'b0;
        net_valid_o = 1'b0;
        case (state)
            L_IDLE: begin
                if (start_i) begin
                    state_nxt = L_SEND;
                end
            end
            L_SEND: begin
                net_valid_o = 1'b1;
                if (core_err) begin
                    set_err   = 1'b1;
                    state_nxt = L_IDLE;
                end else if (net_ready_i) begin
                    state_nxt = L_WAIT_RUN;
                end
            end
            L_WAIT_RUN: begin
                if (core_err || wd_expire) begin
                    set_err   = core_err;
                    state_nxt = L_IDLE;
                end else if (core_run) begin
                    state_nxt = L_RUN;
                end
            end
            L_RUN: begin
                // Error and watchdog both outrank a simultaneous return to IDLE.
                if (core_err || wd_expire) begin
                    set_err   = core_err;
                    state_nxt = L_IDLE;
                end else if (core_idle) begin
                    done_o    = 1'b1;
                    state_nxt = L_IDLE;
                end
            end
            default: state_nxt = L_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= L_IDLE;
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pc_q  <= start_pc_i;
                err_q <= 1'b0;
            end else if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign net_pc_o = pc_q;
    assign busy_o   = (state != L_IDLE);
    assign err_o    = err_q;

endmodule

// File: tb/tb_net_pc_launcher.sv
// tb/tb_net_pc_launcher.sv - directed self-checking bench for net_pc_launcher
module tb_net_pc_launcher;

    localparam int AW = 10;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          start_i;
    logic [AW-1:0] start_pc_i;
    logic          net_valid_o;
    logic          net_ready_i;
    logic [AW-1:0] net_pc_o;
    logic [1:0]    core_state_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          timeout_o;

    int            checks = 0;
    int            errors = 0;
    int            pkt_cnt = 0;
    int            done_cnt = 0;
    logic [AW-1:0] last_pc = '0;
    logic          seen_3ff = 1'b0;

    net_pc_launcher #(
        .IMEM_ADDR_W(AW),
        .TIMEOUT_W  (TW)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .start_i     (start_i),
        .start_pc_i  (start_pc_i),
        .net_valid_o (net_valid_o),
        .net_ready_i (net_ready_i),
        .net_pc_o    (net_pc_o),
        .core_state_i(core_state_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (net_valid_o && net_ready_i) begin
            pkt_cnt = pkt_cnt + 1;
            last_pc = net_pc_o;
        end
        if (done_o) done_cnt = done_cnt + 1;
        if (net_pc_o == 10'h3FF) seen_3ff = 1'b1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0; start_i = 1'b0; start_pc_i = '0;
        net_ready_i = 1'b0; core_state_i = 2'd0;
        #2;
        checks++;
        if ({busy_o, net_valid_o, done_o, err_o, timeout_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags actual=%b expected=00000", {busy_o, net_valid_o, done_o, err_o, timeout_o});
        end
        checks++;
        if (net_pc_o !== 10'h000) begin
            errors++;
            $display("FAIL reset_pc actual=%h expected=000", net_pc_o);
        end
        step(2);
        n_reset = 1'b1;
        net_ready_i = 1'b1;
        step(3);
        net_ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || pkt_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_packet busy=%b pkts=%0d expected busy=0 pkts=0", busy_o, pkt_cnt);
        end
    endtask

    task automatic test_normal_launch();
        int bp, bd;
        bp = pkt_cnt; bd = done_cnt;
        start_i = 1'b1; start_pc_i = 10'h05A;
        step(1);
        start_i = 1'b0; start_pc_i = 10'h000;
        #1;
        checks++;
        if (net_valid_o !== 1'b1 || net_pc_o !== 10'h05A) begin
            errors++;
            $display("FAIL launch_latency valid=%b pc=%h expected valid=1 pc=05a", net_valid_o, net_pc_o);
        end
        step(2);
        net_ready_i = 1'b1;
        step(1);
        net_ready_i = 1'b0;
        checks++;
        if (net_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL launch_after_hs valid=%b busy=%b expected valid=0 busy=1", net_valid_o, busy_o);
        end
        core_state_i = 2'd1;
        step(20);
        core_state_i = 2'd0;
        #1;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL launch_done_pulse actual=%b expected=1", done_o);
        end
        step(1);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL launch_end done=%b busy=%b err=%b expected 0 0 0", done_o, busy_o, err_o);
        end
        checks++;
        if (pkt_cnt !== bp + 1 || last_pc !== 10'h05A || done_cnt !== bd + 1) begin
            errors++;
            $display("FAIL launch_counts pkts=%0d pc=%h dones=%0d expected pkts=%0d pc=05a dones=%0d",
                     pkt_cnt - bp, last_pc, done_cnt - bd, 1, 1);
        end
    endtask

    task automatic test_backpressure();
        int   bp;
        logic hold_ok;
        bp = pkt_cnt; hold_ok = 1'b1;
        start_i = 1'b1; start_pc_i = 10'h1C3;
        step(1);
        start_i = 1'b0; start_pc_i = 10'h2AA;
        for (int i = 0; i < 50; i++) begin
            if (net_valid_o !== 1'b1 || net_pc_o !== 10'h1C3) hold_ok = 1'b0;
            step(1);
        end
        checks++;
        if (hold_ok !== 1'b1 || pkt_cnt !== bp) begin
            errors++;
            $display("FAIL bp_hold stable=%b pkts=%0d expected stable=1 pkts=0", hold_ok, pkt_cnt - bp);
        end
        net_ready_i = 1'b1;
        step(1);
        net_ready_i = 1'b0;
        checks++;
        if (pkt_cnt !== bp + 1 || last_pc !== 10'h1C3 || net_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept pkts=%0d pc=%h valid=%b expected pkts=1 pc=1c3 valid=0",
                     pkt_cnt - bp, last_pc, net_valid_o);
        end
        core_state_i = 2'd1;
        step(1);
        core_state_i = 2'd0;
        start_i = 1'b1;
        #1;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_done actual=%b expected=1", done_o);
        end
        step(1);
        start_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || net_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_cycle busy=%b valid=%b expected 0 0", busy_o, net_valid_o);
        end
    endtask

    task automatic test_core_error();
        int bd;
        bd = done_cnt;
        start_i = 1'b1; start_pc_i = 10'h2B4;
        step(1);
        start_i = 1'b0;
        net_ready_i = 1'b1;
        step(1);
        net_ready_i = 1'b0;
        core_state_i = 2'd1;
        step(4);
        core_state_i = 2'd2;
        step(1);
        core_state_i = 2'd0;
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || done_cnt !== bd) begin
            errors++;
            $display("FAIL err_in_run err=%b busy=%b dones=%0d expected err=1 busy=0 dones=0",
                     err_o, busy_o, done_cnt - bd);
        end
        start_i = 1'b1; start_pc_i = 10'h155;
        step(1);
        start_i = 1'b0;
        checks++;
        if (err_o !== 1'b0 || net_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL err_clear err=%b valid=%b expected err=0 valid=1", err_o, net_valid_o);
        end
        core_state_i = 2'd2;
        step(1);
        core_state_i = 2'd0;
        checks++;
        if (err_o !== 1'b1 || net_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL err_in_send err=%b valid=%b busy=%b expected 1 0 0", err_o, net_valid_o, busy_o);
        end
        start_i = 1'b1; start_pc_i = 10'h0AB;
        step(1);
        start_i = 1'b0;
        net_ready_i = 1'b1;
        step(1);
        net_ready_i = 1'b0;
        core_state_i = 2'd3;
        step(1);
        core_state_i = 2'd0;
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || done_cnt !== bd) begin
            errors++;
            $display("FAIL err_state3 err=%b busy=%b dones=%0d expected err=1 busy=0 dones=0",
                     err_o, busy_o, done_cnt - bd);
        end
    endtask

    task automatic test_ignored_start();
        int bp;
        bp = pkt_cnt; seen_3ff = 1'b0;
        start_i = 1'b1; start_pc_i = 10'h111;
        step(1);
        start_i = 1'b0;
        net_ready_i = 1'b1;
        step(1);
        net_ready_i = 1'b0;
        core_state_i = 2'd1;
        step(1);
        start_i = 1'b1; start_pc_i = 10'h3FF;
        step(3);
        start_i = 1'b0;
        step(2);
        core_state_i = 2'd0;
        step(1);
        checks++;
        if (pkt_cnt !== bp + 1 || last_pc !== 10'h111 || seen_3ff !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start pkts=%0d pc=%h seen3ff=%b expected pkts=1 pc=111 seen3ff=0",
                     pkt_cnt - bp, last_pc, seen_3ff);
        end
        net_ready_i = 1'b1;
        step(3);
        net_ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || pkt_cnt !== bp + 1) begin
            errors++;
            $display("FAIL start_not_queued busy=%b pkts=%0d expected busy=0 pkts=1", busy_o, pkt_cnt - bp);
        end
    endtask

    task automatic test_reset_mid_send();
        int bp;
        bp = pkt_cnt;
        start_i = 1'b1; start_pc_i = 10'h0F0;
        step(1);
        start_i = 1'b0;
        checks++;
        if (net_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_valid actual=%b expected=1", net_valid_o);
        end
        #2;
        n_reset = 1'b0;
        #1;
        checks++;
        if ({net_valid_o, busy_o, done_o, err_o, timeout_o} !== 5'b0 || net_pc_o !== 10'h000) begin
            errors++;
            $display("FAIL rst_async flags=%b pc=%h expected flags=00000 pc=000",
                     {net_valid_o, busy_o, done_o, err_o, timeout_o}, net_pc_o);
        end
        @(negedge clk);
        n_reset = 1'b1;
        net_ready_i = 1'b1;
        step(5);
        net_ready_i = 1'b0;
        checks++;
        if (pkt_cnt !== bp || net_valid_o !== 1'b0 || busy_o !== 1'b0 || net_pc_o !== 10'h000) begin
            errors++;
            $display("FAIL rst_release pkts=%0d valid=%b busy=%b pc=%h expected 0 0 0 000",
                     pkt_cnt - bp, net_valid_o, busy_o, net_pc_o);
        end
    endtask

    task automatic test_timeout();
        int bd;
        bd = done_cnt;
        start_i = 1'b1; start_pc_i = 10'h077;
        step(1);
        start_i = 1'b0;
        net_ready_i = 1'b1;
        step(1);
        net_ready_i = 1'b0;
        core_state_i = 2'd1;
`ifdef NET_LAUNCH_TIMEOUT_EN
        step(14);
        checks++;
        if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL wd_early timeout=%b busy=%b expected timeout=0 busy=1", timeout_o, busy_o);
        end
        step(1);
        checks++;
        if (timeout_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0 || done_cnt !== bd) begin
            errors++;
            $display("FAIL wd_expire timeout=%b busy=%b err=%b dones=%0d expected 1 0 0 0",
                     timeout_o, busy_o, err_o, done_cnt - bd);
        end
        core_state_i = 2'd0;
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL wd_clear actual=%b expected=0", timeout_o);
        end
        core_state_i = 2'd2;
        step(1);
        core_state_i = 2'd0;
`else
        step(40);
        checks++;
        if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL no_wd timeout=%b busy=%b expected timeout=0 busy=1", timeout_o, busy_o);
        end
        core_state_i = 2'd0;
        step(1);
        checks++;
        if (done_cnt !== bd + 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL no_wd_done dones=%0d busy=%b expected dones=1 busy=0", done_cnt - bd, busy_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_normal_launch();
        test_backpressure();
        test_core_error();
        test_ignored_start();
        test_reset_mid_send();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
